bpu_gshare_param: RTL and testbench
===================================

Name: bpu_gshare_param

Overview:
Parametrised next-generation branch predictor for the fetch stage. Provides FETCH_W lookup lanes over a direct-mapped BTB (targets) and a PHT of 2-bit saturating counters (direction). PHT indexing is selectable between bimodal and gshare. The BTB is written from decode, and the PHT and global history are trained from ROB retirement over COMMIT_W lanes.

Parameters:
FETCH_W, 3, number of lookup lanes and decoder write lanes
COMMIT_W, 5, number of ROB retirement update lanes
PHT_BITS, 10, log2 of PHT entries; also the index width
BTB_BITS, 6, log2 of BTB entries (direct-mapped)
GHR_BITS, 8, global history length, must be <= PHT_BITS
GSHARE, 1, 1 = index is pc-derived XOR GHR; 0 = bimodal, pc-derived only

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stall_bpu  in  1  hold all lookup output registers
pc  in  [31:0] x FETCH_W  lookup PCs, word aligned
target_predict  out  [31:0] x FETCH_W  predicted next PC for the lane
target_unsel  out  [31:0] x FETCH_W  the alternative path not chosen
valid_predict  out  1 x FETCH_W  BTB hit
Predict  out  1 x FETCH_W  predicted taken
index  out  [PHT_BITS-1:0] x FETCH_W  PHT index used; carried to the ROB
pc_decoder  in  [31:0] x FETCH_W  decoded instruction PC
isBranch_decoder  in  1 x FETCH_W  BTB write enable per lane
target_decoder  in  [31:0] x FETCH_W  decoded branch target
valid_rob  in  1 x COMMIT_W  retiring branch on this lane
index_rob  in  [PHT_BITS-1:0] x COMMIT_W  PHT index recorded at lookup
Branch_rob  in  1 x COMMIT_W  actual outcome, 1 = taken

Behaviour:
- Reset (asynchronous, immediate):
  - all outputs 0
  - all BTB valid bits 0
  - every PHT counter 2'b01 (weakly not-taken)
  - GHR 0
- Index (registered stage, per lane):
  - raw = pc[PHT_BITS+1:2]
  - GSHARE=1: index = raw XOR {zeros, GHR}
  - GSHARE=0: index = raw
- BTB lookup:
  - set = pc[BTB_BITS+1:2]
  - tag = pc[31:BTB_BITS+2]
  - hit = valid[set] && tag match
- Lookup latency is 1 cycle: the inputs sampled at edge N appear on the outputs after edge N.
- Output decode, per lane:
  - valid_predict = hit
  - Predict = hit && ctr[1]
  - target_predict = Predict ? btb_target : pc+4
  - target_unsel = Predict ? pc+4 : (hit ? btb_target : pc+4)
- stall_bpu=1: all output registers hold their values.
  - BTB writes, PHT training and GHR updates still occur during a stall.
- BTB write (edge):
  - For each lane with isBranch_decoder=1: write the set from pc_decoder with the tag and target, and set valid.
  - Same set written by several lanes in one cycle: the highest lane number wins.
- PHT training (edge):
  - For each lane with valid_rob=1: taken increments the counter saturating at 3; not-taken decrements it saturating at 0.
  - Several lanes hitting the same index in one cycle: apply sequentially in ascending lane order, so the net change is bounded by saturation. Example: counter 2, T,T,N gives 2.
- GHR (edge): shift in each valid retiring outcome in ascending lane order.
  - Lane i's bit lands older than lane i+1's.
  - The LSB is the newest outcome.
  - Invalid lanes are skipped.
- Read/write collisions:
  - Lookup and training in the same cycle: lookup sees the pre-update PHT, GHR and BTB.
  - No bypass.
- Reset mid-operation: in-flight lookups are discarded; outputs go to 0 asynchronously.

Test Plan:
- Reset, then lookup pc=0x1C000000 in all lanes -> after 1 cycle: valid_predict=0, Predict=0, target_predict=0x1C000004, target_unsel=0x1C000004.
- Decoder writes pc=0x1C000010 target=0x1C000100 with GSHARE=0, then lookup -> hit, counter 01 so Predict=0, target_predict=0x1C000014, target_unsel=0x1C000100.
- Retire 2x taken on index 4 (0x1C000010>>2 low bits) -> counter 3 -> lookup gives Predict=1, target_predict=0x1C000100, target_unsel=0x1C000014.
  - Then retire 5 not-taken on index 4 across one cycle -> counter saturates at 0.
- GSHARE=1, retire T,N,T on lanes 0..2 from GHR=0 -> GHR=8'b00000101; lookup of raw index 0x010 yields index 0x015.
- stall_bpu high for 3 cycles while pc changes -> all outputs hold their pre-stall values; a BTB write during the stall is visible on the first lookup after release.
- Two decoder lanes write the same BTB set with targets 0xA0 and 0xB0 (lanes 0,1) -> a lookup returns 0xB0.
  - Assert rst mid-stream -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/bpu_gshare_param.sv
// Fetch-stage branch predictor: FETCH_W lookup lanes over a direct-mapped BTB
// (targets) and a PHT of 2-bit saturating counters (direction), with bimodal
// or gshare indexing. The BTB is filled from decode; the PHT and global
// history are trained from ROB retirement over COMMIT_W lanes.
module bpu_gshare_param #(
    parameter int FETCH_W  = 3,
    parameter int COMMIT_W = 5,
    parameter int PHT_BITS = 10,
    parameter int BTB_BITS = 6,
    parameter int GHR_BITS = 8,
    parameter int GSHARE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_bpu,
    input  logic [31:0]         pc               [FETCH_W],
    output logic [31:0]         target_predict   [FETCH_W],
    output logic [31:0]         target_unsel     [FETCH_W],
    output logic                valid_predict    [FETCH_W],
    output logic                Predict          [FETCH_W],
    output logic [PHT_BITS-1:0] index            [FETCH_W],
    input  logic [31:0]         pc_decoder       [FETCH_W],
    input  logic                isBranch_decoder [FETCH_W],
    input  logic [31:0]         target_decoder   [FETCH_W],
    input  logic                valid_rob        [COMMIT_W],
    input  logic [PHT_BITS-1:0] index_rob        [COMMIT_W],
    input  logic                Branch_rob       [COMMIT_W]
);

    localparam int PHT_N = 1 << PHT_BITS;
    localparam int BTB_N = 1 << BTB_BITS;
    localparam int TAG_W = 30 - BTB_BITS;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Predictor state
    logic [1:0]          pht     [PHT_N];
    logic                btb_vld [BTB_N];
    logic [TAG_W-1:0]    btb_tag [BTB_N];
    logic [31:0]         btb_tgt [BTB_N];
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_nxt;
    logic [PHT_BITS-1:0] ghr_ext;

    // Lookup stage p0 (combinational) and its registered copy p1
    logic [PHT_BITS-1:0] idx_p0   [FETCH_W];
    logic [BTB_BITS-1:0] set_p0   [FETCH_W];
    logic                hit_p0   [FETCH_W];
    logic                taken_p0 [FETCH_W];
    logic [31:0]         seq_p0   [FETCH_W];
    logic [31:0]         tp_p0    [FETCH_W];
    logic [31:0]         tu_p0    [FETCH_W];

    logic [31:0]         tp_p1    [FETCH_W];
    logic [31:0]         tu_p1    [FETCH_W];
    logic                vld_p1   [FETCH_W];
    logic                taken_p1 [FETCH_W];
    logic [PHT_BITS-1:0] idx_p1   [FETCH_W];

    // Per-retire-lane counter value after all same-index lanes up to it
    logic [1:0]          upd_p0   [COMMIT_W];

    // Byte-offset bits of word-aligned PCs carry no information
    logic                pc_lsb_unused;

    assign ghr_ext = PHT_BITS'(ghr);

    // Stage p0: index formation, BTB tag match and output decode per lane
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (GSHARE != 0) begin
                idx_p0[i] = pc[i][PHT_BITS+1:2] ^ ghr_ext;
            end else begin
                idx_p0[i] = pc[i][PHT_BITS+1:2];
            end
            set_p0[i]   = pc[i][BTB_BITS+1:2];
            hit_p0[i]   = btb_vld[set_p0[i]] && (btb_tag[set_p0[i]] == pc[i][31:BTB_BITS+2]);
            taken_p0[i] = hit_p0[i] && pht[idx_p0[i]][1];
            seq_p0[i]   = pc[i] + 32'd4;
            tp_p0[i]    = taken_p0[i] ? btb_tgt[set_p0[i]] : seq_p0[i];
            tu_p0[i]    = taken_p0[i] ? seq_p0[i] : (hit_p0[i] ? btb_tgt[set_p0[i]] : seq_p0[i]);
        end
    end

    // Fold unused low PC bits into one ignored net
    always_comb begin
        pc_lsb_unused = 1'b0;
        for (int i = 0; i < FETCH_W; i++) begin
            pc_lsb_unused = pc_lsb_unused ^ (^pc[i][1:0]) ^ (^pc_decoder[i][1:0]);
        end
    end

    // Stage p0 -> p1: lookup output registers, frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FETCH_W; i++) begin
                tp_p1[i]    <= '0;
                tu_p1[i]    <= '0;
                vld_p1[i]   <= 1'b0;
                taken_p1[i] <= 1'b0;
                idx_p1[i]   <= '0;
            end
        end else if (!stall_bpu) begin
            for (int i = 0; i < FETCH_W; i++) begin
                tp_p1[i]    <= tp_p0[i];
                tu_p1[i]    <= tu_p0[i];
                vld_p1[i]   <= hit_p0[i];
                taken_p1[i] <= taken_p0[i];
                idx_p1[i]   <= idx_p0[i];
            end
        end
    end

    assign target_predict = tp_p1;
    assign target_unsel   = tu_p1;
    assign valid_predict  = vld_p1;
    assign Predict        = taken_p1;
    assign index          = idx_p1;

    // Sequential same-index training: lane j replays every earlier lane on its index
    always_comb begin
        for (int j = 0; j < COMMIT_W; j++) begin
            upd_p0[j] = pht[index_rob[j]];
            for (int k = 0; k <= j; k++) begin
                if (valid_rob[k] && (index_rob[k] == index_rob[j])) begin
                    upd_p0[j] = Branch_rob[k] ? sat_inc(upd_p0[j]) : sat_dec(upd_p0[j]);
                end
            end
        end
    end

    // PHT write-back; the highest lane on an index carries the full chain and lands last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < PHT_N; e++) begin
                pht[e] <= 2'b01;
            end
        end else begin
            for (int j = 0; j < COMMIT_W; j++) begin
                if (valid_rob[j]) begin
                    pht[index_rob[j]] <= upd_p0[j];
                end
            end
        end
    end

    // Global history: shift retiring outcomes in lane order, newest in the LSB
    always_comb begin
        ghr_nxt = ghr;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (valid_rob[j]) begin
                ghr_nxt = {ghr_nxt[GHR_BITS-2:0], Branch_rob[j]};
            end
        end
    end

    // Global history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_nxt;
        end
    end

    // BTB valid bits; ascending lane order lets the highest lane win a shared set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < BTB_N; s++) begin
                btb_vld[s] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (isBranch_decoder[i]) begin
                    btb_vld[pc_decoder[i][BTB_BITS+1:2]] <= 1'b1;
                end
            end
        end
    end

    // BTB tag and target payload, qualified by the valid bits above
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (isBranch_decoder[i]) begin
                btb_tag[pc_decoder[i][BTB_BITS+1:2]] <= pc_decoder[i][31:BTB_BITS+2];
                btb_tgt[pc_decoder[i][BTB_BITS+1:2]] <= target_decoder[i];
            end
        end
    end

endmodule

// File: tb/tb_bpu_gshare_param.sv
// Directed bench for bpu_gshare_param: a bimodal and a gshare instance share
// all inputs; expected values are hand-computed constants.
module tb_bpu_gshare_param;

    localparam int FW = 3;
    localparam int CW = 5;
    localparam int PB = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_bpu;
    logic [31:0]   pc        [FW];
    logic [31:0]   pc_dec    [FW];
    logic          isb_dec   [FW];
    logic [31:0]   tgt_dec   [FW];
    logic          valid_rob [CW];
    logic [PB-1:0] index_rob [CW];
    logic          br_rob    [CW];

    logic [31:0]   tp_b [FW], tu_b [FW], tp_g [FW], tu_g [FW];
    logic          vp_b [FW], pr_b [FW], vp_g [FW], pr_g [FW];
    logic [PB-1:0] ix_b [FW], ix_g [FW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bpu_gshare_param #(.GSHARE(0)) dut_b (
        .clk(clk), .rst(rst), .stall_bpu(stall_bpu), .pc(pc),
        .target_predict(tp_b), .target_unsel(tu_b), .valid_predict(vp_b),
        .Predict(pr_b), .index(ix_b), .pc_decoder(pc_dec),
        .isBranch_decoder(isb_dec), .target_decoder(tgt_dec),
        .valid_rob(valid_rob), .index_rob(index_rob), .Branch_rob(br_rob)
    );

    bpu_gshare_param #(.GSHARE(1)) dut_g (
        .clk(clk), .rst(rst), .stall_bpu(stall_bpu), .pc(pc),
        .target_predict(tp_g), .target_unsel(tu_g), .valid_predict(vp_g),
        .Predict(pr_g), .index(ix_g), .pc_decoder(pc_dec),
        .isBranch_decoder(isb_dec), .target_decoder(tgt_dec),
        .valid_rob(valid_rob), .index_rob(index_rob), .Branch_rob(br_rob)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input int l, input logic vp, input logic pr,
                         input logic [31:0] tp, input logic [31:0] tu);
        chk({tag, "_vp"}, 32'(vp_b[l]), 32'(vp));
        chk({tag, "_pr"}, 32'(pr_b[l]), 32'(pr));
        chk({tag, "_tp"}, tp_b[l], tp);
        chk({tag, "_tu"}, tu_b[l], tu);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_rob();
        for (int j = 0; j < CW; j++) begin
            valid_rob[j] = 1'b0;
            index_rob[j] = '0;
            br_rob[j]    = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_bpu = 1'b0;
        for (int i = 0; i < FW; i++) begin
            pc[i] = 32'h1C000000; pc_dec[i] = '0; isb_dec[i] = 1'b0; tgt_dec[i] = '0;
        end
        clear_rob();

        // Reset state
        #2;
        for (int i = 0; i < FW; i++) begin
            chk("rst_b", tp_b[i], 32'h0);
            chk("rst_g", 32'({vp_g[i], pr_g[i], ix_g[i]}), 32'h0);
        end
        tick();
        rst = 1'b0;

        // Cold lookup: miss, fall-through on both paths
        tick();
        for (int i = 0; i < FW; i++) begin
            chk_b("cold", i, 1'b0, 1'b0, 32'h1C000004, 32'h1C000004);
            chk("cold_ix", 32'(ix_b[i]), 32'h0);
        end

        // BTB fill then hit with weakly-not-taken counter
        pc_dec[0] = 32'h1C000010; tgt_dec[0] = 32'h1C000100; isb_dec[0] = 1'b1;
        tick();
        isb_dec[0] = 1'b0;
        pc[0] = 32'h1C000010;
        tick();
        chk_b("hit_nt", 0, 1'b1, 1'b0, 32'h1C000014, 32'h1C000100);
        chk("hit_ix_b", 32'(ix_b[0]), 32'h004);
        chk("hit_ix_g", 32'(ix_g[0]), 32'h004);

        // Two taken on index 4; the concurrent lookup sees the old counter
        valid_rob[0] = 1'b1; index_rob[0] = 10'h004; br_rob[0] = 1'b1;
        valid_rob[1] = 1'b1; index_rob[1] = 10'h004; br_rob[1] = 1'b1;
        tick();
        clear_rob();
        chk("coll_pr", 32'(pr_b[0]), 32'h0);
        tick();
        chk_b("taken", 0, 1'b1, 1'b1, 32'h1C000100, 32'h1C000014);

        // Five not-taken in one cycle saturate at 0
        for (int j = 0; j < CW; j++) begin
            valid_rob[j] = 1'b1; index_rob[j] = 10'h004; br_rob[j] = 1'b0;
        end
        tick();
        clear_rob();
        tick();
        chk_b("sat0", 0, 1'b1, 1'b0, 32'h1C000014, 32'h1C000100);
        valid_rob[2] = 1'b1; index_rob[2] = 10'h004; br_rob[2] = 1'b1;
        tick();
        clear_rob();
        tick();
        chk("sat0_t1", 32'(pr_b[0]), 32'h0);
        valid_rob[4] = 1'b1; index_rob[4] = 10'h004; br_rob[4] = 1'b1;
        tick();
        clear_rob();
        tick();
        chk("sat0_t2", 32'(pr_b[0]), 32'h1);

        // Gshare history: reset, then T,N,T on lanes 0..2
        rst = 1'b1;
        #1;
        rst = 1'b0;
        pc[0] = 32'h1C000040;
        valid_rob[0] = 1'b1; index_rob[0] = 10'h3FF; br_rob[0] = 1'b1;
        valid_rob[1] = 1'b1; index_rob[1] = 10'h3FF; br_rob[1] = 1'b0;
        valid_rob[2] = 1'b1; index_rob[2] = 10'h3FF; br_rob[2] = 1'b1;
        tick();
        clear_rob();
        chk("ghr_pre", 32'(ix_g[0]), 32'h010);
        tick();
        chk("ghr_101", 32'(ix_g[0]), 32'h015);
        chk("bim_ix", 32'(ix_b[0]), 32'h010);
        // Lanes 1 (T) and 3 (N) only: GHR 101 -> 10110
        valid_rob[1] = 1'b1; index_rob[1] = 10'h3FF; br_rob[1] = 1'b1;
        valid_rob[3] = 1'b1; index_rob[3] = 10'h3FF; br_rob[3] = 1'b0;
        tick();
        clear_rob();
        tick();
        chk("ghr_order", 32'(ix_g[0]), 32'h006);

        // Stall holds outputs; BTB write during stall lands
        for (int i = 0; i < FW; i++) pc[i] = 32'h1C000020;
        tick();
        chk_b("pre_stall", 0, 1'b0, 1'b0, 32'h1C000024, 32'h1C000024);
        stall_bpu = 1'b1;
        for (int i = 0; i < FW; i++) pc[i] = 32'h1C000030;
        pc_dec[1] = 32'h1C000030; tgt_dec[1] = 32'h1C000300; isb_dec[1] = 1'b1;
        tick();
        isb_dec[1] = 1'b0;
        chk("stall1_tp", tp_b[0], 32'h1C000024);
        chk("stall1_ix", 32'(ix_b[2]), 32'h008);
        tick();
        chk("stall2_tp", tp_b[2], 32'h1C000024);
        tick();
        chk("stall3_tp", tp_b[1], 32'h1C000024);
        stall_bpu = 1'b0;
        tick();
        chk_b("post_stall0", 0, 1'b1, 1'b0, 32'h1C000034, 32'h1C000300);
        chk_b("post_stall2", 2, 1'b1, 1'b0, 32'h1C000034, 32'h1C000300);
        chk("post_stall_ix", 32'(ix_b[0]), 32'h00C);

        // Same set written by lanes 0 and 1: lane 1 wins; other tag misses
        pc_dec[0] = 32'h1C000050; tgt_dec[0] = 32'h000000A0; isb_dec[0] = 1'b1;
        pc_dec[1] = 32'h1C000050; tgt_dec[1] = 32'h000000B0; isb_dec[1] = 1'b1;
        tick();
        isb_dec[0] = 1'b0; isb_dec[1] = 1'b0;
        pc[0] = 32'h1C000050;
        pc[2] = 32'h1C000150;
        tick();
        chk_b("same_set", 0, 1'b1, 1'b0, 32'h1C000054, 32'h000000B0);
        chk_b("tag_miss", 2, 1'b0, 1'b0, 32'h1C000154, 32'h1C000154);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tp", tp_b[0], 32'h0);
        chk("arst_tu", tu_b[0], 32'h0);
        chk("arst_vp", 32'(vp_b[0]), 32'h0);
        chk("arst_g", tu_g[2], 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk_b("after_arst", 0, 1'b0, 1'b0, 32'h1C000054, 32'h1C000054);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
